// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator/checker family: FSM states,
// error-counter width and parity-mode constants.
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      HOLD   = 2'd3
   } state_e;

   localparam int unsigned ERR_CNT_W = 8;

   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity: reduction XOR of the data word, inverted for odd mode.
module parity_calc #(
   parameter int unsigned W = 3
) (
   input  logic [W-1:0] data_i,
   input  logic         odd_i,
   output logic         parity_o
);

   assign parity_o = (^data_i) ^ odd_i;

endmodule

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: DATA_W data bits (LSB first) plus a parity bit, result
// held over valid/ready. Define PARITY_ERR_CNT_EN to add the saturating err_count.
module parity_frame_checker
   import parity_pkg::*;
#(
   parameter int unsigned DATA_W     = 3,
   parameter int unsigned ODD_PARITY = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_valid,
   input  logic              bit_in,
   input  logic              frame_start,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              parity_err,
   output logic              overrun,
   output logic              busy
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_count
`endif
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                perr_q, perr_d;
   logic                overrun_q, overrun_d;
   logic                valid_q, busy_q;
   logic                exp_par_c;
   logic                start_c;
   logic                load_c;

   parity_calc #(.W(DATA_W)) u_calc (
      .data_i   (shift_q),
      .odd_i    ((ODD_PARITY != 0) ? ODD : EVEN),
      .parity_o (exp_par_c)
   );

   // Next-state logic; a frame_start bit outside HOLD (or with a HOLD handshake) restarts the frame.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      shift_d   = shift_q;
      data_d    = data_q;
      perr_d    = perr_q;
      overrun_d = 1'b0;
      start_c   = 1'b0;
      load_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bit_valid && frame_start) start_c = 1'b1;
         end
         DATA: begin
            if (bit_valid) begin
               if (frame_start) begin
                  start_c = 1'b1;
               end else begin
                  for (int unsigned i = 0; i < DATA_W; i++) begin
                     if (count_q == CNT_W'(i)) shift_d[i] = bit_in;
                  end
                  count_d = count_q + CNT_W'(1);
                  if (count_q == CNT_W'(DATA_W - 1)) state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (bit_valid) begin
               if (frame_start) begin
                  start_c = 1'b1;
               end else begin
                  perr_d  = bit_in ^ exp_par_c;
                  data_d  = shift_q;
                  count_d = '0;
                  load_c  = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               if (bit_valid && frame_start) begin
                  start_c = 1'b1;
               end else begin
                  overrun_d = bit_valid;
                  state_d   = IDLE;
               end
            end else begin
               overrun_d = bit_valid;
            end
         end
         default: state_d = IDLE;
      endcase
      if (start_c) begin
         shift_d    = '0;
         shift_d[0] = bit_in;
         count_d    = CNT_W'(1);
         state_d    = (DATA_W == 1) ? PARITY : DATA;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         perr_q    <= 1'b0;
         overrun_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         perr_q    <= perr_d;
         overrun_q <= overrun_d;
         valid_q   <= (state_d == HOLD);
         busy_q    <= (state_d != IDLE);
      end
   end

   assign out_valid  = valid_q;
   assign data_out   = data_q;
   assign parity_err = perr_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

`ifdef PARITY_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Saturating count of frames loaded into HOLD with a parity error.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (load_c && perr_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker: directed frames push expected
// results; a negedge monitor pops and compares on every handshake.
module tb_parity_frame_checker;
   import parity_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bit_valid, bit_in, frame_start, out_ready;
   logic       out_valid, parity_err, overrun, busy;
   logic [2:0] data_out;

   logic       o_bit_valid, o_bit_in, o_frame_start;
   logic       o_out_valid, o_parity_err, o_overrun, o_busy;
   logic [2:0] o_data_out;
`ifdef PARITY_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_count, o_err_count;
`endif

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   parity_frame_checker #(.DATA_W(3), .ODD_PARITY(0)) dut (
      .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
      .frame_start(frame_start), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .parity_err(parity_err), .overrun(overrun), .busy(busy)
`ifdef PARITY_ERR_CNT_EN
      , .err_count(err_count)
`endif
   );

   parity_frame_checker #(.DATA_W(3), .ODD_PARITY(1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .bit_valid(o_bit_valid), .bit_in(o_bit_in),
      .frame_start(o_frame_start), .out_valid(o_out_valid), .out_ready(1'b1),
      .data_out(o_data_out), .parity_err(o_parity_err), .overrun(o_overrun), .busy(o_busy)
`ifdef PARITY_ERR_CNT_EN
      , .err_count(o_err_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One valid bit, sampled at the next rising edge.
   task automatic send(input logic b, input logic fs);
      bit_valid = 1'b1; bit_in = b; frame_start = fs;
      @(posedge clk); #1;
      bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0;
   endtask

   // Full frame: data bits d[0..2] then parity bit p; expected result queued.
   task automatic frame(input logic [2:0] d, input logic p, input logic exp_err);
      exp_q.push_back({exp_err, d});
      send(d[0], 1'b1);
      send(d[1], 1'b0);
      send(d[2], 1'b0);
      send(p, 1'b0);
   endtask

   task automatic send_odd(input logic b, input logic fs);
      o_bit_valid = 1'b1; o_bit_in = b; o_frame_start = fs;
      @(posedge clk); #1;
      o_bit_valid = 1'b0; o_bit_in = 1'b0; o_frame_start = 1'b0;
   endtask

   // Monitor: every accepted result must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got data=%0h err=%0b expected none", data_out, parity_err);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            chk("sb_data", 32'(data_out), 32'(e[2:0]));
            chk("sb_perr", 32'(parity_err), 32'(e[3]));
         end
      end
   end

   initial begin
      rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
      o_bit_valid = 1'b0; o_bit_in = 1'b0; o_frame_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overrun", 32'(overrun), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Good frame, then latency check
      frame(3'b011, 1'b0, 1'b0);
      chk("latency_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
      chk("idle_after_hs", 32'(busy), 0);

      // Errored frame
      frame(3'b111, 1'b0, 1'b1);
      chk("err_valid", 32'(out_valid), 1);
`ifdef PARITY_ERR_CNT_EN
      chk("err_count_1", 32'(err_count), 1);
`endif
      @(posedge clk); #1;

      // Backpressure with a dropped bit in cycle 3
      out_ready = 1'b0;
      frame(3'b010, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin bit_valid = 1'b1; bit_in = 1'b1; frame_start = 1'b1; end
         @(posedge clk); #1;
         bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0;
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_data", 32'(data_out), 32'h2);
         chk("bp_perr", 32'(parity_err), 0);
         chk("bp_overrun", 32'(overrun), (i == 2) ? 1 : 0);
      end
      // Handshake plus same-cycle frame_start: new frame 1,0,1 parity 0
      out_ready = 1'b1;
      exp_q.push_back({1'b0, 3'b101});
      send(1'b1, 1'b1);
      chk("hs_start_overrun", 32'(overrun), 0);
      chk("hs_start_valid", 32'(out_valid), 0);
      chk("hs_start_busy", 32'(busy), 1);
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      @(posedge clk); #1;

      // Restart mid-frame: 1,0 then frame_start 1,0,0 parity 1
      send(1'b1, 1'b1);
      send(1'b0, 1'b0);
      exp_q.push_back({1'b0, 3'b001});
      send(1'b1, 1'b1);
      send(1'b0, 1'b0);
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      chk("restart_no_overrun", 32'(overrun), 0);
      @(posedge clk); #1;

      // Asynchronous reset mid-frame
      send(1'b1, 1'b1);
      send(1'b1, 1'b0);
      chk("pre_rst_busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_data", 32'(data_out), 0);
      chk("arst_perr", 32'(parity_err), 0);
      chk("arst_overrun", 32'(overrun), 0);
      chk("arst_busy", 32'(busy), 0);
`ifdef PARITY_ERR_CNT_EN
      chk("arst_err_count", 32'(err_count), 0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      frame(3'b110, 1'b0, 1'b0);
      @(posedge clk); #1;

`ifdef PARITY_ERR_CNT_EN
      for (int i = 0; i < 260; i++) frame(3'b001, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("err_count_sat", 32'(err_count), 255);
`endif

      // Odd parity instance
      send_odd(1'b0, 1'b1);
      send_odd(1'b0, 1'b0);
      send_odd(1'b0, 1'b0);
      send_odd(1'b1, 1'b0);
      chk("odd_valid", 32'(o_out_valid), 1);
      chk("odd_data", 32'(o_data_out), 0);
      chk("odd_perr_ok", 32'(o_parity_err), 0);
      @(posedge clk); #1;
      send_odd(1'b1, 1'b1);
      send_odd(1'b0, 1'b0);
      send_odd(1'b0, 1'b0);
      send_odd(1'b1, 1'b0);
      chk("odd_perr_bad", 32'(o_parity_err), 1);
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
